wheel_speed_meter: RTL
======================

# wheel_speed_meter

Downstream of the quadrature wheel interface: consumes its free-running 8-bit tick count and direction levels, and measures signed wheel displacement over a fixed sampling window. Each window produces a speed magnitude, a direction and a moving flag, delivered through a valid/ready output register to the speed controller. An optional 4-window moving average smooths the magnitude.

## Interface
- WINDOW_CYCLES, 50000: sampling window length in clk cycles (1 ms at 50 MHz); must be ≥ 2.
- CNT_W, 8: width of the input tick count.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 resets).
- count  input  CNT_W  tick count from the wheel interface; wraps mod 2^CNT_W.
- cw  input  1  clockwise-step level from the wheel interface; informational only.
- ccw  input  1  counter-clockwise-step level; informational only.
- speed  output  CNT_W  magnitude of ticks per window, unsigned.
- dir  output  1  1 = positive (CW) displacement, 0 = negative (CCW).
- moving  output  1  1 when the window delta is nonzero.
- out_valid  output  1  result register holds an unconsumed sample.
- out_ready  input  1  consumer accepts the sample.
- overrun  output  1  an unconsumed sample was overwritten.

## Operation
- FSM states: INIT, RUN. Reset enters INIT.
- INIT: one cycle; latches count into prev_cnt, sets win_cnt = 0, then moves to RUN.
- RUN: win_cnt increments each cycle. On the cycle where win_cnt == WINDOW_CYCLES-1, the block samples:
  - delta = (count − prev_cnt) mod 2^CNT_W, interpreted as a two's-complement CNT_W-bit value.
  - prev_cnt ← count; win_cnt ← 0.
  - speed ← |delta|, with no saturation. For CNT_W = 8, −128 gives 128.
  - dir ← sign of delta (1 if delta > 0, 0 if delta < 0). When delta = 0, dir holds its previous value.
  - moving ← (delta ≠ 0).
  - out_valid ← 1.
- Wrap-around: count 250 → 4 gives delta = +10. Count 4 → 250 gives delta = −10.
- Handshake:
  - A handshake occurs on an edge where out_valid & out_ready; out_valid then clears.
  - out_valid holds while out_ready is low.
  - speed, dir and moving are stable while out_valid = 1, except when overwritten.
- Simultaneous handshake and new sample on the same edge: the new sample loads, out_valid stays 1, and no overrun is raised.
- New sample while out_valid = 1 and out_ready = 0: outputs are overwritten and overrun ← 1.
- overrun clears on the next handshake edge.
- Reset asserted mid-window: all state is discarded immediately and the block restarts from INIT. No partial sample is produced.

## Timing
- Reset values:
  - State = INIT, win_cnt = 0, prev_cnt = 0.
  - Outputs: speed = 0, dir = 0, moving = 0, out_valid = 0, overrun = 0.
- Edge 1 after reset release executes INIT.
- The first sample is taken at edge WINDOW_CYCLES+1, and out_valid is high after that edge.
- Later samples follow every WINDOW_CYCLES edges exactly. Period is independent of the handshake.
- Latency: count is sampled at the sampling edge, and outputs are valid immediately after that edge (1 register stage).
- out_ready is sampled only on rising edges and has no combinational path to any output.

## Configuration
- WHEEL_SPEED_AVG_EN defined:
  - speed = (sum of last 4 window magnitudes) >> 2.
  - The history is 4 × CNT_W registers and the sum is CNT_W+2 bits. Both are cleared by reset, so the average ramps up from 0 over the first 4 samples.
  - dir and moving still use the current window only.
- WHEEL_SPEED_AVG_EN undefined: speed is the raw current-window magnitude and no history registers exist.

## Structure
- Shared package wheel_pkg:
  - State enum (INIT, RUN).
  - Default window constant.
  - Count width constant, shared with the wheel interface.
- Sub-module speed_avg4: the 4-entry magnitude history and averaging adder. It is instantiated only under WHEEL_SPEED_AVG_EN.
- Everything else (window counter, delta arithmetic, output register and handshake) lives in wheel_speed_meter.

## Test plan
- WINDOW_CYCLES = 8, count held at 0, out_ready = 1 → first out_valid after edge 9, with speed = 0 and moving = 0. Then one sample every 8 edges.
- count steps 10 → 30 within a window → speed = 20, dir = 1, moving = 1. Then 30 → 25 → speed = 5, dir = 0.
- Wrap: 250 → 4 gives speed 10, dir 1. 4 → 250 gives speed 10, dir 0. 0 → 128 gives speed 128, dir 0.
- out_ready = 0 across two samples → second sample overwrites and overrun = 1. Next handshake clears both out_valid and overrun.
- out_ready rises exactly on a sampling edge → new sample loads, out_valid stays 1, overrun stays 0.
- Reset pulled low at win_cnt = 5 → all outputs go to 0 immediately. After release, the first sample arrives after edge 9. With WHEEL_SPEED_AVG_EN and deltas of 40 per window, speed reads 10, 20, 30, 40.

Source files
------------

// File: rtl/wheel_pkg.sv
// Shared wheel-path definitions: meter FSM states, default sampling window, tick count width.
package wheel_pkg;

    localparam int WHEEL_CNT_W         = 8;
    localparam int WHEEL_WINDOW_CYCLES = 50000;

    typedef enum logic {
        INIT,
        RUN
    } meter_state_e;

endpackage

// File: rtl/speed_avg4.sv
// Four-window magnitude history and averaging adder for wheel_speed_meter
// (used only when WHEEL_SPEED_AVG_EN is defined).
module speed_avg4
    import wheel_pkg::*;
#(
    parameter int CNT_W = WHEEL_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] mag,
    output logic [CNT_W-1:0] avg
);

    logic [CNT_W-1:0] hist [4];
    logic [CNT_W+1:0] sum;

    // NOTE: the history is a handful of registers, not a RAM, so it is cleared on
    // reset; that makes the average ramp up from 0 instead of starting from garbage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if (load) begin
            hist[0] <= mag;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    // Summed from registered history only, so the average changes exactly when a
    // new window loads, in step with dir and moving.
    always_comb begin
        sum = (CNT_W+2)'(hist[0]) + (CNT_W+2)'(hist[1])
            + (CNT_W+2)'(hist[2]) + (CNT_W+2)'(hist[3]);
    end

    assign avg = sum[CNT_W+1:2];

endmodule

// File: rtl/wheel_speed_meter.sv
// Measures signed wheel displacement per fixed window and presents it through a
// valid/ready result register. Define WHEEL_SPEED_AVG_EN for a 4-window averaged speed.
module wheel_speed_meter
    import wheel_pkg::*;
#(
    parameter int WINDOW_CYCLES = WHEEL_WINDOW_CYCLES,
    parameter int CNT_W         = WHEEL_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    input  logic             cw,
    input  logic             ccw,
    output logic [CNT_W-1:0] speed,
    output logic             dir,
    output logic             moving,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int              WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    meter_state_e     state, state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] prev_cnt;
    logic [CNT_W-1:0] delta;
    logic [CNT_W-1:0] mag;
    logic             sample;
    logic             handshake;

    // Direction levels are carried for traceability only; displacement comes from count.
    logic unused_dir_levels;
    assign unused_dir_levels = cw ^ ccw;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        case (state)
            INIT: state_nxt = RUN;
            RUN:  sample    = (win_cnt == WIN_LAST);
            default: state_nxt = INIT;
        endcase
    end

    // Modular subtraction gives the signed step directly across count wrap-around;
    // the magnitude of the most negative value stays representable as unsigned.
    assign delta     = count - prev_cnt;
    assign mag       = delta[CNT_W-1] ? (CNT_W'(0) - delta) : delta;
    assign handshake = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt  <= '0;
            prev_cnt <= '0;
        end else if (state == INIT || sample) begin
            win_cnt  <= '0;
            prev_cnt <= count;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir       <= 1'b0;
            moving    <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (sample) begin
                moving <= |delta;
                if (|delta) dir <= ~delta[CNT_W-1];
            end
            out_valid <= sample | (out_valid & ~out_ready);
            // A sample landing on a handshake edge replaces a consumed result, not a pending one.
            if (sample && out_valid && !out_ready) overrun <= 1'b1;
            else if (handshake)                    overrun <= 1'b0;
        end
    end

`ifdef WHEEL_SPEED_AVG_EN
    speed_avg4 #(
        .CNT_W (CNT_W)
    ) u_avg (
        .clk   (clk),
        .reset (reset),
        .load  (sample),
        .mag   (mag),
        .avg   (speed)
    );
`else
    logic [CNT_W-1:0] speed_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      speed_q <= '0;
        else if (sample) speed_q <= mag;
    end

    assign speed = speed_q;
`endif

endmodule
